// File: rtl/clk_phase_meter_pkg.sv
// Shared state encodings and timer width for the clock phase meter.
// Default-parameter constants; modules derive their own widths with tmr_w().
package clk_phase_meter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} top_state_t;
    typedef enum logic [1:0] {WAIT_FIRST, COUNT, FIN} chan_state_t;

    localparam int CNT_W_DEF    = 16;
    localparam int AVG_LOG2_DEF = 3;
    localparam int TMR_W        = CNT_W_DEF + AVG_LOG2_DEF;

    function automatic int tmr_w(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/clk_phase_meter_chan.sv
// One sampled clock: synchroniser, rising-edge detect, first/last edge timestamps and result maths.
// Edge flagged SYNC_STAGES+1 cycles after it occurs; no backpressure, results are combinational from latches.
module clk_phase_meter_chan
    import clk_phase_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 3,
    parameter int SYNC_STAGES = 2,
    localparam int TW         = CNT_W + AVG_LOG2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             smp,
    input  logic             active,
    input  logic [TW-1:0]    tmr,
    output logic             rise,
    output logic             err_res,
    output logic [CNT_W-1:0] period_res,
    output logic [CNT_W-1:0] phase_res
);

    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] PH_MAX   = TW'((64'd1 << CNT_W) - 64'd1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    chan_state_t            st;
    logic [CW-1:0]          cnt;
    logic [TW-1:0]          f_ts;
    logic [TW-1:0]          t_ts;
    logic [TW-1:0]          span;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], smp};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    // The timer reads 0 in the arm cycle, so an arm-cycle edge naturally latches f=0.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st   <= WAIT_FIRST;
            cnt  <= '0;
            f_ts <= '0;
            t_ts <= '0;
        end else if (!active) begin
            st  <= WAIT_FIRST;
            cnt <= '0;
        end else if (rise) begin
            case (st)
                WAIT_FIRST: begin
                    f_ts <= tmr;
                    cnt  <= '0;
                    st   <= COUNT;
                end
                COUNT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        t_ts <= tmr;
                        st   <= FIN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign span = t_ts - f_ts;

    always_comb begin
        err_res    = (st != FIN);
        period_res = span[TW-1:AVG_LOG2];
        phase_res  = (f_ts > PH_MAX) ? '1 : f_ts[CNT_W-1:0];
        if (err_res) begin
            period_res = '1;
            phase_res  = '1;
        end
    end

endmodule

// File: rtl/clk_phase_meter.sv
// Measures averaged period and phase vs channel 0 of NUM_CH oversampled clocks; result registered one cycle after DONE.
// No backpressure: start while busy is ignored. CLK_PHASE_METER_CONT_EN selects continuous re-arming.
module clk_phase_meter
    import clk_phase_meter_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    locked,
    input  logic [NUM_CH-1:0]       clk_smp,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH*CNT_W-1:0] period,
    output logic [NUM_CH*CNT_W-1:0] phase,
    output logic [NUM_CH-1:0]       err
);

    localparam int TW = tmr_w(CNT_W, AVG_LOG2);

    top_state_t                state;
    logic [TW-1:0]             tmr;
    logic [NUM_CH-1:0]         ch_rise;
    logic [NUM_CH-1:0]         ch_err;
    logic [NUM_CH*CNT_W-1:0]   ch_period;
    logic [NUM_CH*CNT_W-1:0]   ch_phase;
    logic                      arm;
    logic                      active;
    logic                      abort;

    assign arm    = (state == ARM) && ch_rise[0];
    assign active = arm || (state == MEAS);
    assign abort  = ((state == ARM || state == MEAS) && !locked) ||
                    (state == IDLE && start && !locked);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_phase_meter_chan #(
            .CNT_W       (CNT_W),
            .AVG_LOG2    (AVG_LOG2),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .smp        (clk_smp[i]),
            .active     (active),
            .tmr        (tmr),
            .rise       (ch_rise[i]),
            .err_res    (ch_err[i]),
            .period_res (ch_period[i*CNT_W +: CNT_W]),
            .phase_res  (ch_phase[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            tmr    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            period <= '0;
            phase  <= '0;
            err    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                tmr    <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
                period <= '1;
                phase  <= '1;
                err    <= '1;
            end else begin
                case (state)
                    IDLE: begin
                        tmr <= '0;
                        if (start) begin
                            state <= ARM;
                            busy  <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (ch_rise[0]) begin
                            tmr   <= TW'(1);
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (!(|ch_err) || (&tmr)) state <= DONE;
                        else                      tmr   <= tmr + 1'b1;
                    end
                    default: begin
                        done   <= 1'b1;
                        period <= ch_period;
                        phase  <= ch_phase;
                        err    <= ch_err;
                        tmr    <= '0;
`ifdef CLK_PHASE_METER_CONT_EN
                        state  <= locked ? ARM : IDLE;
                        busy   <= locked;
`else
                        state  <= IDLE;
                        busy   <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/clk_phase_meter.md
Name: clk_phase_meter

Overview:
Multi-channel clock monitor that oversamples NUM_CH slow clocks (e.g. the clk_wiz 33 MHz outputs and their phase-shifted copies) as data in one fast clock domain (e.g. clk_100m). Per channel, it measures the averaged period and the rising-edge phase offset relative to channel 0, in sys_clk cycles. It replaces ad-hoc ILA probing of wizard outputs with a register-readable, self-checking measurement. Gated by the wizard's locked output.

Parameters:
NUM_CH, 2, number of sampled clocks; channel 0 is the phase reference.
CNT_W, 16, width of each period/phase result.
AVG_LOG2, 3, periods averaged per channel = 2^AVG_LOG2.
SYNC_STAGES, 2, synchroniser flops per channel (>=2).

Ports:
sys_clk  in  1  measuring clock.
sys_rst  in  1  reset; asynchronous, active-high.
locked  in  1  wizard lock; measurement is valid only while high.
clk_smp  in  NUM_CH  sampled clocks, asynchronous to sys_clk.
start  in  1  one-cycle request to begin a measurement.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when results update.
period  out  NUM_CH*CNT_W  averaged period of channel i in bits [i*CNT_W +: CNT_W].
phase  out  NUM_CH*CNT_W  delay of channel i's first rising edge after the channel-0 arm edge; phase[0] is always 0.
err  out  NUM_CH  per-channel failure flag.

Behaviour:
- Reset (async, sys_rst=1): busy=0, done=0, period=0, phase=0, err=0; all FSMs go to IDLE.
- Per channel: SYNC_STAGES-flop synchroniser plus one edge flop. A rising edge is flagged SYNC_STAGES+1 cycles after it occurs. The latency is equal on all channels, so it cancels in phase.
- Timer T is CNT_W+AVG_LOG2 bits wide, saturating.
- Top FSM:
  - IDLE: start=1 && locked=1 -> ARM, busy=1. start=1 && locked=0 -> next cycle done=1, err=all ones, period/phase=all ones.
  - ARM: wait for a channel-0 rising edge. On that edge T=0 -> MEAS.
  - MEAS: T increments each cycle. Exit when every channel is finished or T saturates -> DONE.
  - DONE: one cycle. Results are registered, done=1, busy=0 -> IDLE.
- Channel FSM (active in MEAS; the arm edge counts as a channel edge):
  - WAIT_FIRST: on an edge, latch f_i=T (an edge in the arm cycle gives f_i=0), edge count=0 -> COUNT.
  - COUNT: each edge increments the count. On the 2^AVG_LOG2-th edge, latch t_i=T -> FIN.
  - Results: period_i = (t_i - f_i) >> AVG_LOG2; phase_i = f_i, saturated to CNT_W all-ones if larger.
- Timeout: a channel not in FIN when T saturates gets err_i=1 and period_i=phase_i=all ones. Other channels report normally.
- locked falling during ARM or MEAS aborts: next cycle done=1, busy=0, err=all ones, results all ones.
- start while busy is ignored. sys_rst mid-measurement clears everything immediately; no done pulse.
- Results hold until the next done.

Optional Feature:
CLK_PHASE_METER_CONT_EN:
- Defined: continuous mode. DONE returns to ARM (not IDLE) while locked=1, start is ignored, and busy stays 1 after the first start.
- Undefined: one-shot as above.

Decomposition:
- Package clk_phase_meter_pkg: top state enum (IDLE, ARM, MEAS, DONE), channel state enum (WAIT_FIRST, COUNT, FIN), and derived constant TMR_W=CNT_W+AVG_LOG2.
- Sub-module clk_phase_meter_chan, instantiated NUM_CH times: synchroniser, edge detect, channel FSM, f_i/t_i latches and result arithmetic.

Test Plan:
1. locked=1, ch0 period 6 (3 high/3 low), ch1 identical but delayed 2 cycles, start pulse -> exactly one done; period[0]=period[1]=6, phase[1]=2, err=0.
2. ch1 = ch0 delayed 3 cycles (180 deg) -> phase[1]=3, period[1]=6, err=0.
3. ch1 held low -> done after T saturates (2^19-1 cycles); err=2'b10, period[1]=phase[1]=16'hFFFF, period[0]=6.
4. locked dropped mid-MEAS -> done one cycle later, busy=0, err=2'b11, all results 16'hFFFF; start with locked=0 -> same response.
5. sys_rst pulsed mid-MEAS -> all outputs 0 immediately, no done; after release, scenario 1 repeated passes.
6. With CLK_PHASE_METER_CONT_EN, single start -> done pulses every measurement with identical results; busy stays 1.
